fir_param: RTL and testbench

- Parametrised direct-form FIR filter; next generation of the fixed 9-tap, 12-bit filter.
- Sits between the data source and the sink, using the same DIN/VIN and DOUT/VOUT valid-qualified streaming style.
- Adds generic tap count and widths.
- Adds a runtime-programmable, double-buffered coefficient bank.
- Adds a delay-line flush.
- Adds saturating output scaling.

---
 rtl/fir_param_if.sv | 43 ++++
 rtl/fir_param.sv | 129 ++++++++++++
 tb/tb_fir_param.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_param_if.sv
// ----------------------------------------------------------------------------
// fir_param_if : streaming + coefficient-programming bundle for fir_param.
//
//   master : drives DIN/VIN/CLEAR and the coefficient port, receives DOUT/VOUT
//   slave  : the filter side (receives samples, produces results)
//
//   DIN         signed input sample, qualified by VIN
//   VIN         sample valid
//   CLEAR       synchronous delay-line flush
//   COEF_WE     shadow coefficient write enable
//   COEF_ADDR   shadow coefficient index (0 = newest-sample tap)
//   COEF_DATA   signed coefficient value
//   COEF_COMMIT copy shadow bank to active bank
//   DOUT        signed filtered output, qualified by VOUT
//   VOUT        one-cycle result valid pulse
// ----------------------------------------------------------------------------
interface fir_param_if #(
   parameter int unsigned DW = 12,
   parameter int unsigned CW = 12,
   parameter int unsigned AW = 4
);

   logic signed [DW-1:0] DIN;
   logic                 VIN;
   logic                 CLEAR;
   logic                 COEF_WE;
   logic [AW-1:0]        COEF_ADDR;
   logic signed [CW-1:0] COEF_DATA;
   logic                 COEF_COMMIT;
   logic signed [DW-1:0] DOUT;
   logic                 VOUT;

   modport master (
      output DIN, VIN, CLEAR, COEF_WE, COEF_ADDR, COEF_DATA, COEF_COMMIT,
      input  DOUT, VOUT
   );

   modport slave (
      input  DIN, VIN, CLEAR, COEF_WE, COEF_ADDR, COEF_DATA, COEF_COMMIT,
      output DOUT, VOUT
   );

endinterface

// File: rtl/fir_param.sv
// ----------------------------------------------------------------------------
// fir_param : parametrised direct-form FIR filter, two-stage pipeline.
//
//   Stage 1 : delay line x[0..N_TAPS-1] shifts on every accepted sample
//             (VIN=1); CLEAR flushes it (flush-then-accept when both are set).
//   Stage 2 : full-precision sum of x[i]*A[i] with the active coefficient
//             bank, arithmetic right shift by SHIFT, saturation to DW bits.
//   Coefficients are written into a shadow bank and become visible only on
//   COEF_COMMIT; a write on the commit edge is carried through.
//
//   Ports:
//     CLK  clock, rising edge
//     RST  synchronous active-high reset, dominates all other inputs
//     bus  fir_param_if.slave (samples in, coefficient port, results out)
//
//   Latency: a sample accepted at edge k shows DOUT/VOUT after edge k+1.
// ----------------------------------------------------------------------------
module fir_param #(
   parameter int unsigned N_TAPS = 9,
   parameter int unsigned DW     = 12,
   parameter int unsigned CW     = 12,
   parameter int unsigned SHIFT  = 11
) (
   input  logic         CLK,
   input  logic         RST,
   fir_param_if.slave   bus
);

   localparam int unsigned PW   = DW + CW;
   localparam int unsigned AccW = DW + CW + $clog2(N_TAPS);

   // Output clamp limits expressed in accumulator width.
   localparam logic signed [AccW-1:0] YMAX = (AccW'(1) <<< (DW - 1)) - AccW'(1);
   localparam logic signed [AccW-1:0] YMIN = -(AccW'(1) <<< (DW - 1));

   // Delay line and stage-1 valid flag.
   logic signed [DW-1:0] x      [N_TAPS];
   logic                 v1;

   // Coefficient banks.
   logic signed [CW-1:0] shadow     [N_TAPS];
   logic signed [CW-1:0] shadow_c   [N_TAPS];
   logic signed [CW-1:0] active     [N_TAPS];

   // Datapath (combinational).
   logic signed [PW-1:0]   prod_c [N_TAPS];
   logic signed [AccW-1:0] acc_c;
   logic signed [AccW-1:0] y_c;
   logic signed [DW-1:0]   sat_c;

   // Registered outputs.
   logic signed [DW-1:0] dout;
   logic                 vout;

   // Stage 1: delay line shift / flush.
   always_ff @(posedge CLK) begin
      if (RST) begin
         x  <= '{default: '0};
         v1 <= 1'b0;
      end else if (bus.VIN) begin
         x[0] <= bus.DIN;
         for (int i = 1; i < int'(N_TAPS); i++) begin
            x[i] <= bus.CLEAR ? '0 : x[i-1];
         end
         v1 <= 1'b1;
      end else begin
         if (bus.CLEAR) begin
            x <= '{default: '0};
         end
         v1 <= 1'b0;
      end
   end

   // Shadow bank after this edge's write; also the source for a commit so
   // that a write on the commit edge lands in the active bank.
   always_comb begin
      shadow_c = shadow;
      if (bus.COEF_WE && (32'(bus.COEF_ADDR) < N_TAPS)) begin
         shadow_c[bus.COEF_ADDR] = bus.COEF_DATA;
      end
   end

   // Coefficient bank registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow <= '{default: '0};
         active <= '{default: '0};
      end else begin
         shadow <= shadow_c;
         if (bus.COEF_COMMIT) begin
            active <= shadow_c;
         end
      end
   end

   // Stage 2 datapath: exact products, exact sum, floor shift, clamp.
   always_comb begin
      acc_c = '0;
      for (int i = 0; i < int'(N_TAPS); i++) begin
         prod_c[i] = PW'(x[i]) * PW'(active[i]);
         acc_c     = acc_c + AccW'(prod_c[i]);
      end
      y_c = acc_c >>> SHIFT;
      if (y_c > YMAX) begin
         sat_c = YMAX[DW-1:0];
      end else if (y_c < YMIN) begin
         sat_c = YMIN[DW-1:0];
      end else begin
         sat_c = y_c[DW-1:0];
      end
   end

   // Stage 2 output register; DOUT holds between results.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dout <= '0;
         vout <= 1'b0;
      end else begin
         vout <= v1;
         if (v1) begin
            dout <= sat_c;
         end
      end
   end

   assign bus.DOUT = dout;
   assign bus.VOUT = vout;

endmodule

// File: tb/tb_fir_param.sv
// ----------------------------------------------------------------------------
// tb_fir_param : scoreboard bench for fir_param.
// Two instances share one stimulus stream: u0 with SHIFT=0, u1 with SHIFT=11.
// A behavioural model pushes each expected result when a sample is accepted;
// the monitors pop on VOUT. Directed checks compare logged outputs to the
// hand-derived values of each scenario.
// ----------------------------------------------------------------------------
module tb_fir_param;

   localparam int unsigned N  = 9;
   localparam int unsigned DW = 12;
   localparam int unsigned CW = 12;
   localparam int unsigned AW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] din;
   logic                 vin;
   logic                 clr;
   logic                 cwe;
   logic [AW-1:0]        cad;
   logic signed [CW-1:0] cdat;
   logic                 ccm;

   fir_param_if #(.DW(DW), .CW(CW), .AW(AW)) if0 ();
   fir_param_if #(.DW(DW), .CW(CW), .AW(AW)) if1 ();

   assign if0.DIN = din;  assign if0.VIN = vin;  assign if0.CLEAR = clr;
   assign if0.COEF_WE = cwe;  assign if0.COEF_ADDR = cad;
   assign if0.COEF_DATA = cdat;  assign if0.COEF_COMMIT = ccm;
   assign if1.DIN = din;  assign if1.VIN = vin;  assign if1.CLEAR = clr;
   assign if1.COEF_WE = cwe;  assign if1.COEF_ADDR = cad;
   assign if1.COEF_DATA = cdat;  assign if1.COEF_COMMIT = ccm;

   fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .SHIFT(0)) u0 (
      .CLK(clk), .RST(rst), .bus(if0)
   );
   fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .SHIFT(11)) u1 (
      .CLK(clk), .RST(rst), .bus(if1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int  mx   [N];
   int  msh  [N];
   int  mact [N];
   bit  m_v1 = 1'b0;
   bit  m_vexp = 1'b0;
   bit  m_rst_edge = 1'b0;
   int  q0 [$];
   int  q1 [$];

   function automatic int fir_ref(input int sh);
      longint acc;
      longint y;
      longint lim;
      acc = 0;
      for (int i = 0; i < int'(N); i++) acc += longint'(mx[i]) * longint'(mact[i]);
      y   = acc >>> sh;
      lim = longint'(1) <<< (DW - 1);
      if (y > lim - 1) y = lim - 1;
      if (y < -lim)    y = -lim;
      return int'(y);
   endfunction

   always @(posedge clk) begin
      m_rst_edge = rst;
      if (rst) begin
         for (int i = 0; i < int'(N); i++) begin
            mx[i] = 0; msh[i] = 0; mact[i] = 0;
         end
         m_v1   = 1'b0;
         m_vexp = 1'b0;
         q0.delete();
         q1.delete();
      end else begin
         m_vexp = m_v1;
         if (cwe && (int'(cad) < int'(N))) msh[cad] = int'(cdat);
         if (ccm) for (int i = 0; i < int'(N); i++) mact[i] = msh[i];
         if (clr) for (int i = 0; i < int'(N); i++) mx[i] = 0;
         m_v1 = vin;
         if (vin) begin
            for (int i = int'(N) - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = int'(din);
            q0.push_back(fir_ref(0));
            q1.push_back(fir_ref(11));
         end
      end
   end

   // ---------------- monitors ----------------
   int obs0 [$];
   int obs1 [$];
   int last0 = 0;
   int last1 = 0;

   always @(negedge clk) begin
      chk("vout0", int'(if0.VOUT), int'(m_vexp));
      chk("vout1", int'(if1.VOUT), int'(m_vexp));
      if (m_rst_edge) begin
         chk("rst_dout0", int'(if0.DOUT), 0);
         chk("rst_dout1", int'(if1.DOUT), 0);
         last0 = 0;
         last1 = 0;
      end else begin
         if (if0.VOUT) begin
            chk("q0_has", int'(q0.size() > 0), 1);
            if (q0.size() > 0) chk("dout0", int'(if0.DOUT), q0.pop_front());
            obs0.push_back(int'(if0.DOUT));
            last0 = int'(if0.DOUT);
         end else begin
            chk("hold0", int'(if0.DOUT), last0);
         end
         if (if1.VOUT) begin
            chk("q1_has", int'(q1.size() > 0), 1);
            if (q1.size() > 0) chk("dout1", int'(if1.DOUT), q1.pop_front());
            obs1.push_back(int'(if1.DOUT));
            last1 = int'(if1.DOUT);
         end else begin
            chk("hold1", int'(if1.DOUT), last1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      vin = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic send(input int d);
      vin = 1'b1;
      din = DW'(d);
      cyc();
      vin = 1'b0;
   endtask

   task automatic write_coef(input int a, input int d);
      cwe  = 1'b1;
      cad  = AW'(a);
      cdat = CW'(d);
      cyc();
      cwe  = 1'b0;
   endtask

   task automatic commit();
      ccm = 1'b1;
      cyc();
      ccm = 1'b0;
   endtask

   task automatic clear_logs();
      obs0.delete();
      obs1.delete();
   endtask

   // ---------------- scenarios ----------------
   initial begin
      rst = 1'b1; din = '0; vin = 1'b0; clr = 1'b0;
      cwe = 1'b0; cad = '0; cdat = '0; ccm = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      idle(2);

      // Impulse: taps 1..9, continuous VIN.
      for (int i = 0; i < int'(N); i++) write_coef(i, i + 1);
      commit();
      clear_logs();
      send(1);
      for (int i = 0; i < 9; i++) send(0);
      idle(3);
      chk("imp_n", obs0.size(), 10);
      if (obs0.size() == 10) for (int i = 0; i < 10; i++) chk("imp", obs0[i], (i < 9) ? i + 1 : 0);

      // Same impulse with three idle cycles between samples.
      clear_logs();
      send(1);
      idle(3);
      for (int i = 0; i < 9; i++) begin
         send(0);
         idle(3);
      end
      chk("gap_n", obs0.size(), 10);
      if (obs0.size() == 10) for (int i = 0; i < 10; i++) chk("gap", obs0[i], (i < 9) ? i + 1 : 0);

      // Saturation with SHIFT=11.
      for (int i = 0; i < int'(N); i++) write_coef(i, 2047);
      commit();
      clear_logs();
      for (int i = 0; i < 9; i++) send(2047);
      for (int i = 0; i < 9; i++) send(-2048);
      idle(3);
      chk("sat_n", obs1.size(), 18);
      if (obs1.size() == 18) begin
         chk("sat_pos", obs1[8], 2047);
         chk("sat_neg", obs1[17], -2048);
      end

      // Double buffering: shadow writes invisible until commit.
      for (int i = 0; i < int'(N); i++) write_coef(i, 1);
      commit();
      for (int i = 0; i < 9; i++) send(100);
      idle(2);
      clear_logs();
      vin = 1'b1;
      din = DW'(100);
      for (int i = 0; i < int'(N); i++) write_coef(i, 2);
      write_coef(15, 7);
      commit();
      cyc();
      cyc();
      idle(3);
      chk("dbuf_n", obs0.size(), 13);
      if (obs0.size() == 13) begin
         chk("dbuf_first", obs0[0], 900);
         chk("dbuf_pre", obs0[9], 900);
         chk("dbuf_commit", obs0[10], 1800);
         chk("dbuf_after", obs0[12], 1800);
      end

      // CLEAR with VIN: flush then accept.
      for (int i = 0; i < int'(N); i++) write_coef(i, 1);
      commit();
      send(100);
      send(100);
      idle(2);
      clear_logs();
      clr = 1'b1;
      send(100);
      clr = 1'b0;
      for (int i = 0; i < 8; i++) send(100);
      idle(3);
      chk("clr_n", obs0.size(), 9);
      if (obs0.size() == 9) for (int i = 0; i < 9; i++) chk("clr", obs0[i], 100 * (i + 1));

      // Reset in the middle of a continuous stream.
      send(100);
      send(100);
      send(100);
      vin = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      clear_logs();
      send(100);
      send(100);
      send(100);
      idle(3);
      chk("rst_n", obs0.size(), 3);
      if (obs0.size() == 3) for (int i = 0; i < 3; i++) chk("rst_out0", obs0[i], 0);
      if (obs1.size() == 3) for (int i = 0; i < 3; i++) chk("rst_out1", obs1[i], 0);

      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
